// File: rtl/rtr_route_sched_if.sv
// Request/grant bundle between route filters, the per-port switch scheduler and the crossbar.
interface rtr_route_sched_if #(
  parameter int unsigned num_vcs              = 4,
  parameter int unsigned num_ports            = 5,
  parameter int unsigned num_resource_classes = 2
);
  logic [0:num_vcs-1]                      req_vc;
  logic [0:num_vcs-1]                      req_head;
  logic [0:num_vcs-1]                      req_tail;
  logic [0:num_vcs*num_ports-1]            route_op;
  logic [0:num_vcs*num_resource_classes-1] route_orc;
  logic [0:num_vcs*2-1]                    filter_errors;
  logic [0:num_ports-1]                    xbar_ready;
  logic                                    gnt_valid;
  logic [0:num_vcs-1]                      gnt_vc;
  logic [0:num_ports-1]                    gnt_op;
  logic [0:num_resource_classes-1]         gnt_orc;
  logic                                    locked;
  logic [0:1]                              error_sticky;

  modport master (
    output req_vc, req_head, req_tail, route_op, route_orc, filter_errors, xbar_ready,
    input  gnt_valid, gnt_vc, gnt_op, gnt_orc, locked, error_sticky
  );

  modport slave (
    input  req_vc, req_head, req_tail, route_op, route_orc, filter_errors, xbar_ready,
    output gnt_valid, gnt_vc, gnt_op, gnt_orc, locked, error_sticky
  );
endinterface

// File: rtl/rtr_route_sched.sv
// Per-input-port switch scheduler: round-robin VC pick, packet lock until tail.
// Optional sticky filter-error latch enabled by RTR_ROUTE_SCHED_ERRORS_EN.
module rtr_route_sched #(
  parameter int unsigned num_vcs              = 4,
  parameter int unsigned num_ports            = 5,
  parameter int unsigned num_resource_classes = 2
) (
  input logic              clk,
  input logic              reset,
  rtr_route_sched_if.slave bus
);
  localparam int unsigned vc_w  = (num_vcs > 1) ? $clog2(num_vcs) : 1;
  localparam int unsigned op_w  = (num_ports > 1) ? $clog2(num_ports) : 1;
  localparam int unsigned orc_w = (num_resource_classes > 1) ? $clog2(num_resource_classes) : 1;

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e            state_q;
  logic [vc_w-1:0]   ptr_q;
  logic [vc_w-1:0]   sv_q;
  logic [op_w-1:0]   sop_q;
  logic [orc_w-1:0]  sorc_q;
  logic              gnt_valid_q;
  logic [0:num_vcs-1]              gnt_vc_q;
  logic [0:num_ports-1]            gnt_op_q;
  logic [0:num_resource_classes-1] gnt_orc_q;
  logic              locked_q;

  logic [op_w-1:0]   cand_op  [num_vcs];
  logic [orc_w-1:0]  cand_orc [num_vcs];
  logic [0:num_vcs-1] eligible;
  logic              any_op, any_orc;

  logic              pick_valid, pick_tail;
  logic [vc_w-1:0]   pick_vc, ptr_next;
  logic [op_w-1:0]   pick_op;
  logic [orc_w-1:0]  pick_orc;
  logic [0:num_vcs-1]              vc_oh;
  logic [0:num_ports-1]            op_oh;
  logic [0:num_resource_classes-1] orc_oh;
  int                idx;

  // Candidate port/class per VC is the lowest set bit of its filtered mask.
  always_comb begin
    any_op  = 1'b0;
    any_orc = 1'b0;
    for (int v = 0; v < int'(num_vcs); v++) begin
      cand_op[v]  = '0;
      cand_orc[v] = '0;
      any_op      = 1'b0;
      any_orc     = 1'b0;
      for (int p = int'(num_ports) - 1; p >= 0; p--) begin
        if (bus.route_op[v*int'(num_ports)+p]) begin
          cand_op[v] = op_w'(p);
          any_op     = 1'b1;
        end
      end
      for (int c = int'(num_resource_classes) - 1; c >= 0; c--) begin
        if (bus.route_orc[v*int'(num_resource_classes)+c]) begin
          cand_orc[v] = orc_w'(c);
          any_orc     = 1'b1;
        end
      end
      eligible[v] = bus.req_vc[v] & bus.req_head[v] & any_op & any_orc &
                    bus.xbar_ready[cand_op[v]];
    end
  end

  always_comb begin
    pick_valid = 1'b0;
    pick_tail  = 1'b0;
    pick_vc    = '0;
    pick_op    = '0;
    pick_orc   = '0;
    idx        = 0;
    if (state_q == StIdle) begin
      // Scan farthest-first so the VC nearest the pointer wins.
      for (int i = int'(num_vcs) - 1; i >= 0; i--) begin
        idx = (int'(ptr_q) + i) % int'(num_vcs);
        if (eligible[idx]) begin
          pick_valid = 1'b1;
          pick_vc    = vc_w'(idx);
          pick_op    = cand_op[idx];
          pick_orc   = cand_orc[idx];
          pick_tail  = bus.req_tail[idx];
        end
      end
    end else begin
      pick_valid = bus.req_vc[sv_q] & bus.xbar_ready[sop_q];
      pick_tail  = bus.req_tail[sv_q];
      pick_vc    = sv_q;
      pick_op    = sop_q;
      pick_orc   = sorc_q;
    end
    ptr_next         = vc_w'((int'(pick_vc) + 1) % int'(num_vcs));
    vc_oh            = '0;
    vc_oh[pick_vc]   = 1'b1;
    op_oh            = '0;
    op_oh[pick_op]   = 1'b1;
    orc_oh           = '0;
    orc_oh[pick_orc] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      sv_q        <= '0;
      sop_q       <= '0;
      sorc_q      <= '0;
      gnt_valid_q <= 1'b0;
      gnt_vc_q    <= '0;
      gnt_op_q    <= '0;
      gnt_orc_q   <= '0;
      locked_q    <= 1'b0;
    end else begin
      gnt_valid_q <= pick_valid;
      if (pick_valid) begin
        gnt_vc_q  <= vc_oh;
        gnt_op_q  <= op_oh;
        gnt_orc_q <= orc_oh;
      end
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            sv_q   <= pick_vc;
            sop_q  <= pick_op;
            sorc_q <= pick_orc;
            ptr_q  <= ptr_next;
            if (!pick_tail) begin
              state_q  <= StLocked;
              locked_q <= 1'b1;
            end
          end
        end
        StLocked: begin
          if (pick_valid && pick_tail) begin
            state_q  <= StIdle;
            locked_q <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_vc    = gnt_vc_q;
  assign bus.gnt_op    = gnt_op_q;
  assign bus.gnt_orc   = gnt_orc_q;
  assign bus.locked    = locked_q;

`ifdef RTR_ROUTE_SCHED_ERRORS_EN
  logic [0:1] err_q;
  logic [0:1] err_set;

  always_comb begin
    err_set = '0;
    for (int v = 0; v < int'(num_vcs); v++) begin
      err_set[0] = err_set[0] | (bus.req_vc[v] & bus.filter_errors[2*v]);
      err_set[1] = err_set[1] | (bus.req_vc[v] & bus.filter_errors[2*v+1]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= '0;
    end else begin
      err_q <= err_q | err_set;
`ifndef SYNTHESIS
      if ((err_q == 2'b00) && (err_set != 2'b00)) begin
        $display("ERROR: route scheduler latched filter error in module %m.");
      end
`endif
    end
  end

  assign bus.error_sticky = err_q;
`else
  logic unused_filter_errors;
  assign unused_filter_errors = ^bus.filter_errors;
  assign bus.error_sticky     = '0;
`endif
endmodule

// File: tb/tb_rtr_route_sched.sv
// Directed table-driven bench for rtr_route_sched plus hand-written lock/fairness sequences.
module tb_rtr_route_sched;
`ifdef RTR_ROUTE_SCHED_ERRORS_EN
  localparam bit err_en = 1'b1;
`else
  localparam bit err_en = 1'b0;
`endif

  localparam logic [4:0] r_all  = 5'b11111;
  localparam logic [7:0] orc_01 = 8'b01010101;
  localparam logic [7:0] orc_v2 = 8'b01011001;
  localparam logic [7:0] orc_v3 = 8'b01010110;
  localparam logic [19:0] op_fair = {5'b10000, 5'b01000, 5'b00100, 5'b00010};

  typedef struct {
    logic        rst;
    logic [3:0]  rv;
    logic [3:0]  hd;
    logic [3:0]  tl;
    logic [19:0] op;
    logic [7:0]  orc;
    logic [7:0]  fe;
    logic [4:0]  rdy;
    logic        gv;
    logic [3:0]  vc;
    logic [4:0]  gop;
    logic [1:0]  gorc;
    logic        lk;
    logic [1:0]  err;
  } row_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_vec = 0;
  int   n_miss = 0;
  row_t vecs[$];

  always #5 clk = ~clk;

  rtr_route_sched_if #(.num_vcs(4), .num_ports(5), .num_resource_classes(2)) bus ();

  rtr_route_sched #(.num_vcs(4), .num_ports(5), .num_resource_classes(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input row_t r);
    @(negedge clk);
    reset             = r.rst;
    bus.req_vc        = r.rv;
    bus.req_head      = r.hd;
    bus.req_tail      = r.tl;
    bus.route_op      = r.op;
    bus.route_orc     = r.orc;
    bus.filter_errors = r.fe;
    bus.xbar_ready    = r.rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input row_t r, input string tag);
    drive(r);
    chk({tag, " gnt_valid"}, 32'(bus.gnt_valid), 32'(r.gv));
    chk({tag, " gnt_vc"}, 32'(bus.gnt_vc), 32'(r.vc));
    chk({tag, " gnt_op"}, 32'(bus.gnt_op), 32'(r.gop));
    chk({tag, " gnt_orc"}, 32'(bus.gnt_orc), 32'(r.gorc));
    chk({tag, " locked"}, 32'(bus.locked), 32'(r.lk));
    chk({tag, " error_sticky"}, 32'(bus.error_sticky), 32'(err_en ? r.err : 2'b00));
  endtask

  initial begin
    row_t r;
    logic [3:0] rv_rand;
    // Field order: rst rv hd tl op orc fe rdy | gv vc gop gorc lk err
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, r_all, 0, 0, 0, 0, 0, 0});
    // Single-flit on VC1 to op2; pointer then sits at VC2.
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, {5'b0, 5'b00100, 10'b0}, orc_01, 0, r_all,
                     1, 4'b0100, 5'b00100, 2'b01, 0, 0});
    vecs.push_back('{0, 4'b1010, 4'b1010, 4'b1010, {5'b10000, 5'b0, 5'b00010, 5'b0}, orc_01, 0,
                     r_all, 1, 4'b0010, 5'b00010, 2'b01, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 0, orc_01, 0, r_all, 0, 4'b0010, 5'b00010, 2'b01, 0, 0});
    // 3-flit packet on VC0 to op1 while VC2 head waits.
    vecs.push_back('{0, 4'b1010, 4'b1010, 4'b0000, {5'b01000, 5'b0, 5'b00001, 5'b0}, orc_v2, 0,
                     r_all, 1, 4'b1000, 5'b01000, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1010, 4'b0010, 4'b0000, {10'b0, 5'b00001, 5'b0}, 8'b00011001, 0,
                     r_all, 1, 4'b1000, 5'b01000, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1010, 4'b0010, 4'b1000, {10'b0, 5'b00001, 5'b0}, orc_v2, 0, r_all,
                     1, 4'b1000, 5'b01000, 2'b01, 0, 0});
    vecs.push_back('{0, 4'b0010, 4'b0010, 4'b0000, {10'b0, 5'b00001, 5'b0}, orc_v2, 0, r_all,
                     1, 4'b0010, 5'b00001, 2'b10, 1, 0});
    vecs.push_back('{0, 4'b0010, 4'b0000, 4'b0010, {10'b0, 5'b00001, 5'b0}, orc_v2, 0, r_all,
                     1, 4'b0010, 5'b00001, 2'b10, 0, 0});
    // Fairness from pointer 0.
    vecs.push_back('{1, 0, 0, 0, 0, 0, 0, r_all, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 4'hf, 4'hf, 4'hf, op_fair, orc_01, 0, r_all,
                     1, 4'b1000, 5'b10000, 2'b01, 0, 0});
    vecs.push_back('{0, 4'hf, 4'hf, 4'hf, op_fair, orc_01, 0, r_all,
                     1, 4'b0100, 5'b01000, 2'b01, 0, 0});
    vecs.push_back('{0, 4'hf, 4'hf, 4'hf, op_fair, orc_01, 0, r_all,
                     1, 4'b0010, 5'b00100, 2'b01, 0, 0});
    vecs.push_back('{0, 4'hf, 4'hf, 4'hf, op_fair, orc_01, 0, r_all,
                     1, 4'b0001, 5'b00010, 2'b01, 0, 0});
    vecs.push_back('{0, 4'hf, 4'hf, 4'hf, op_fair, orc_01, 0, r_all,
                     1, 4'b1000, 5'b10000, 2'b01, 0, 0});
    // Backpressure on op3 while locked to VC0.
    vecs.push_back('{0, 4'b1000, 4'b1000, 0, {5'b00010, 15'b0}, orc_01, 0, r_all,
                     1, 4'b1000, 5'b00010, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1000, 0, 0, {5'b00010, 15'b0}, orc_01, 0, 5'b11101,
                     0, 4'b1000, 5'b00010, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1000, 0, 0, {5'b00010, 15'b0}, orc_01, 0, 5'b11101,
                     0, 4'b1000, 5'b00010, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1000, 0, 0, {5'b00010, 15'b0}, orc_01, 0, r_all,
                     1, 4'b1000, 5'b00010, 2'b01, 1, 0});
    vecs.push_back('{0, 4'b1000, 0, 4'b1000, {5'b00010, 15'b0}, orc_01, 0, r_all,
                     1, 4'b1000, 5'b00010, 2'b01, 0, 0});
    // Illegal route with port error on VC2, then ineligible-request boundaries.
    vecs.push_back('{0, 4'b0010, 4'b0010, 4'b0010, 0, orc_01, 8'b00001000, r_all,
                     0, 4'b1000, 5'b00010, 2'b01, 0, 2'b10});
    vecs.push_back('{0, 0, 0, 0, 0, orc_01, 0, r_all, 0, 4'b1000, 5'b00010, 2'b01, 0, 2'b10});
    vecs.push_back('{0, 4'b0100, 4'b0000, 4'b0100, {5'b0, 5'b00100, 10'b0}, orc_01, 0, r_all,
                     0, 4'b1000, 5'b00010, 2'b01, 0, 2'b10});
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, {5'b0, 5'b00100, 10'b0}, 8'b01000101, 0,
                     r_all, 0, 4'b1000, 5'b00010, 2'b01, 0, 2'b10});
    vecs.push_back('{0, 4'b0100, 4'b0100, 4'b0100, {5'b0, 5'b01100, 10'b0}, orc_01, 0, 5'b10111,
                     0, 4'b1000, 5'b00010, 2'b01, 0, 2'b10});
    // Reset mid-packet on VC3, then a fresh VC3 single-flit.
    vecs.push_back('{0, 4'b0001, 4'b0001, 0, {15'b0, 5'b00001}, orc_v3, 0, r_all,
                     1, 4'b0001, 5'b00001, 2'b10, 1, 2'b10});
    vecs.push_back('{1, 4'b0001, 0, 0, {15'b0, 5'b00001}, orc_v3, 0, r_all, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 4'b0001, 4'b0001, 4'b0001, {15'b0, 5'b00100}, orc_01, 0, r_all,
                     1, 4'b0001, 5'b00100, 2'b01, 0, 0});

    bus.req_vc = '0; bus.req_head = '0; bus.req_tail = '0; bus.route_op = '0;
    bus.route_orc = '0; bus.filter_errors = '0; bus.xbar_ready = '0;

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Locked VC1 with its requests absent: bubbles keep the lock.
    apply('{0, 4'b0100, 4'b0100, 0, {5'b0, 5'b00001, 10'b0}, orc_01, 0, r_all,
            1, 4'b0100, 5'b00001, 2'b01, 1, 0}, "lk_head");
    for (int k = 0; k < 3; k++) begin
      apply('{0, 0, 0, 0, 0, orc_01, 0, r_all, 0, 4'b0100, 5'b00001, 2'b01, 1, 0},
            $sformatf("lk_bubble%0d", k));
    end
    apply('{0, 4'b1100, 4'b1000, 4'b1100, {5'b10000, 5'b00001, 10'b0}, orc_01, 0, r_all,
            1, 4'b0100, 5'b00001, 2'b01, 0, 0}, "lk_tail");
    apply('{0, 4'b1000, 4'b1000, 4'b1000, {5'b10000, 15'b0}, orc_01, 0, r_all,
            1, 4'b1000, 5'b10000, 2'b01, 0, 0}, "lk_after");

    // Random single-flit mixes: a grant whenever anyone requests, always one-hot and requested.
    for (int k = 0; k < 16; k++) begin
      rv_rand = 4'($urandom_range(0, 15));
      r = '{0, rv_rand, rv_rand, rv_rand, op_fair, orc_01, 0, r_all, 0, 0, 0, 0, 0, 0};
      drive(r);
      chk($sformatf("rnd%0d gnt_valid", k), 32'(bus.gnt_valid), 32'(|rv_rand));
      if (rv_rand != 4'b0000) begin
        chk($sformatf("rnd%0d onehot", k), 32'($countones(bus.gnt_vc)), 32'd1);
        chk($sformatf("rnd%0d requested", k), 32'(|(bus.gnt_vc & rv_rand)), 32'd1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
